// File: rtl/head_table_wr_arb_if.sv
// Head-table write-side bus: requester handshakes in, single RAM write port out.
// master drives requests and observes the write port; slave is the arbiter.
interface head_table_wr_arb_if #(
  parameter int BUCKET_WIDTH   = 8,
  parameter int HEAD_PTR_WIDTH = 10,
  parameter int REQ_CNT        = 2
);
  logic [REQ_CNT-1:0]                req_val_i;
  logic [REQ_CNT*BUCKET_WIDTH-1:0]   req_addr_i;
  logic [REQ_CNT*HEAD_PTR_WIDTH-1:0] req_ptr_i;
  logic [REQ_CNT-1:0]                req_ptr_val_i;
  logic [REQ_CNT-1:0]                req_ready_o;

  logic [BUCKET_WIDTH-1:0]           ht_wr_addr_o;
  logic [HEAD_PTR_WIDTH-1:0]         ht_wr_data_ptr_o;
  logic                              ht_wr_data_ptr_val_o;
  logic                              ht_wr_en_o;

  modport master (
    output req_val_i, req_addr_i, req_ptr_i, req_ptr_val_i,
    input  req_ready_o,
    input  ht_wr_addr_o, ht_wr_data_ptr_o, ht_wr_data_ptr_val_o, ht_wr_en_o
  );

  modport slave (
    input  req_val_i, req_addr_i, req_ptr_i, req_ptr_val_i,
    output req_ready_o,
    output ht_wr_addr_o, ht_wr_data_ptr_o, ht_wr_data_ptr_val_o, ht_wr_en_o
  );
endinterface

// File: rtl/head_table_wr_arb.sv
// Head-table write port owner: round-robin arbitration between requesters
// plus a clear sequencer that zeroes every bucket after reset or on command.
//
// state | meaning
// CLEAR | sweeping buckets 0..2**BUCKET_WIDTH-1, writing ptr_val=0; requesters blocked
// RUN   | arbitrating requester writes round-robin onto the write port
module head_table_wr_arb #(
  parameter int BUCKET_WIDTH   = 8,
  parameter int HEAD_PTR_WIDTH = 10,
  parameter int REQ_CNT        = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 clear_start_i,
  output logic                 clear_busy_o,
  output logic                 clear_done_o,
  head_table_wr_arb_if.slave   bus
);

  localparam int RR_W = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;
  localparam logic [BUCKET_WIDTH-1:0] CLR_LAST = '1;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [BUCKET_WIDTH-1:0]   clr_cnt_q;
  logic [RR_W-1:0]           rr_ptr_q;
  logic [RR_W-1:0]           rr_nxt;

  logic [REQ_CNT-1:0]        val_rot;
  logic [REQ_CNT-1:0]        req_ready;
  logic                      grant_vld;
  logic [RR_W-1:0]           grant_idx;
  logic [BUCKET_WIDTH-1:0]   sel_addr;
  logic [HEAD_PTR_WIDTH-1:0] sel_ptr;
  logic                      sel_ptr_val;

  logic [BUCKET_WIDTH-1:0]   wr_addr_q;
  logic [HEAD_PTR_WIDTH-1:0] wr_ptr_q;
  logic                      wr_ptr_val_q;
  logic                      wr_en_q;
  logic                      clear_done_q;

  always_comb begin
    int cand;
    cand        = 0;
    state_d     = state_q;
    req_ready   = '0;
    grant_vld   = 1'b0;
    grant_idx   = '0;
    sel_addr    = '0;
    sel_ptr     = '0;
    sel_ptr_val = 1'b0;
    // Rotate valids so bit k is requester (rr_ptr + k) mod REQ_CNT.
    val_rot     = REQ_CNT'({bus.req_val_i, bus.req_val_i} >> rr_ptr_q);

    case (state_q)
      CLEAR: begin
        if (clr_cnt_q == CLR_LAST) state_d = RUN;
      end
      RUN: begin
        if (clear_start_i) begin
          state_d = CLEAR;
        end else begin
          for (int k = 0; k < REQ_CNT; k++) begin
            if (!grant_vld && val_rot[k]) begin
              grant_vld = 1'b1;
              cand      = int'(rr_ptr_q) + k;
              if (cand >= REQ_CNT) cand = cand - REQ_CNT;
              grant_idx = RR_W'(cand);
            end
          end
          for (int i = 0; i < REQ_CNT; i++) begin
            if (grant_vld && (grant_idx == RR_W'(i))) begin
              req_ready[i] = 1'b1;
              sel_addr     = bus.req_addr_i[i*BUCKET_WIDTH +: BUCKET_WIDTH];
              sel_ptr      = bus.req_ptr_i[i*HEAD_PTR_WIDTH +: HEAD_PTR_WIDTH];
              sel_ptr_val  = bus.req_ptr_val_i[i];
            end
          end
        end
      end
    endcase
  end

  assign rr_nxt = (grant_idx == RR_W'(REQ_CNT - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= CLEAR;
      clr_cnt_q    <= '0;
      rr_ptr_q     <= '0;
      clear_done_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_ptr_q     <= '0;
      wr_ptr_val_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clear_done_q <= 1'b0;
      wr_en_q      <= 1'b0;
      case (state_q)
        CLEAR: begin
          wr_en_q      <= 1'b1;
          wr_addr_q    <= clr_cnt_q;
          wr_ptr_q     <= '0;
          wr_ptr_val_q <= 1'b0;
          if (clr_cnt_q == CLR_LAST) begin
            clr_cnt_q    <= '0;
            clear_done_q <= 1'b1;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (clear_start_i) begin
            clr_cnt_q <= '0;
          end else if (grant_vld) begin
            // Payload regs hold their last value when idle; only wr_en drops.
            wr_en_q      <= 1'b1;
            wr_addr_q    <= sel_addr;
            wr_ptr_q     <= sel_ptr;
            wr_ptr_val_q <= sel_ptr_val;
            rr_ptr_q     <= rr_nxt;
          end
        end
      endcase
    end
  end

  assign clear_busy_o             = (state_q == CLEAR);
  assign clear_done_o             = clear_done_q;
  assign bus.req_ready_o          = req_ready;
  assign bus.ht_wr_en_o           = wr_en_q;
  assign bus.ht_wr_addr_o         = wr_addr_q;
  assign bus.ht_wr_data_ptr_o     = wr_ptr_q;
  assign bus.ht_wr_data_ptr_val_o = wr_ptr_val_q;

endmodule

// File: tb/tb_head_table_wr_arb.sv
// Bench for head_table_wr_arb: expected writes are queued with the cycle they
// must appear on the write port; a negedge monitor pops and compares them.
module tb_head_table_wr_arb;
  localparam int BW = 4;
  localparam int PW = 10;
  localparam int RC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear_start = 1'b0;
  logic clear_busy;
  logic clear_done;

  head_table_wr_arb_if #(.BUCKET_WIDTH(BW), .HEAD_PTR_WIDTH(PW), .REQ_CNT(RC)) hif();

  head_table_wr_arb #(.BUCKET_WIDTH(BW), .HEAD_PTR_WIDTH(PW), .REQ_CNT(RC)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .clear_start_i (clear_start),
    .clear_busy_o  (clear_busy),
    .clear_done_o  (clear_done),
    .bus           (hif.slave)
  );

  typedef struct {
    int            due;
    logic [BW-1:0] addr;
    logic [PW-1:0] ptr;
    logic          pv;
    logic          done;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write-port monitor: each cycle either the queued write is due or the port is idle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        checks++;
        if (hif.ht_wr_en_o !== 1'b1 || hif.ht_wr_addr_o !== mon_e.addr ||
            hif.ht_wr_data_ptr_o !== mon_e.ptr || hif.ht_wr_data_ptr_val_o !== mon_e.pv ||
            clear_done !== mon_e.done) begin
          errors++;
          $display("FAIL wr_port cyc=%0d got en=%b addr=%h ptr=%h pv=%b done=%b required en=1 addr=%h ptr=%h pv=%b done=%b",
                   cyc, hif.ht_wr_en_o, hif.ht_wr_addr_o, hif.ht_wr_data_ptr_o,
                   hif.ht_wr_data_ptr_val_o, clear_done, mon_e.addr, mon_e.ptr, mon_e.pv, mon_e.done);
        end
      end else begin
        checks++;
        if (hif.ht_wr_en_o !== 1'b0 || clear_done !== 1'b0) begin
          errors++;
          $display("FAIL wr_idle cyc=%0d got en=%b done=%b required en=0 done=0",
                   cyc, hif.ht_wr_en_o, clear_done);
        end
      end
    end
  end

  task automatic push_wr(input int due, input logic [BW-1:0] a, input logic [PW-1:0] p,
                         input logic v, input logic d);
    exp_t e;
    e.due = due; e.addr = a; e.ptr = p; e.pv = v; e.done = d;
    sb.push_back(e);
  endtask

  task automatic push_sweep(input int first_due);
    for (int k = 0; k < (1 << BW); k++)
      push_wr(first_due + k, BW'(k), '0, 1'b0, (k == (1 << BW) - 1));
  endtask

  task automatic set_req(input int i, input logic v, input logic [BW-1:0] a,
                         input logic [PW-1:0] p, input logic pv);
    hif.req_val_i[i]            = v;
    hif.req_addr_i[i*BW +: BW]  = a;
    hif.req_ptr_i[i*PW +: PW]   = p;
    hif.req_ptr_val_i[i]        = pv;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    mon_en = 1'b0;
    sb.delete();
    rst_n = 1'b0;
    clear_start = 1'b0;
    set_req(0, 1'b0, '0, '0, 1'b0);
    set_req(1, 1'b0, '0, '0, 1'b0);
    repeat (3) begin
      next_cycle;
      checks++;
      if (clear_busy !== 1'b1 || hif.ht_wr_en_o !== 1'b0 || clear_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_state got busy=%b en=%b done=%b required busy=1 en=0 done=0",
                 clear_busy, hif.ht_wr_en_o, clear_done);
      end
    end
    checks++;
    if (hif.req_ready_o !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready got %b required 00", hif.req_ready_o);
    end
    rst_n = 1'b1;
    set_req(0, 1'b1, 4'h9, 10'h055, 1'b1);
    push_sweep(cyc + 1);
    mon_en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      next_cycle;
      checks++;
      if (clear_busy !== (k < 16) || hif.req_ready_o !== ((k < 16) ? 2'b00 : 2'b01)) begin
        errors++;
        $display("FAIL release_cycle%0d got busy=%b ready=%b required busy=%b ready=%b",
                 k, clear_busy, hif.req_ready_o, (k < 16), ((k < 16) ? 2'b00 : 2'b01));
      end
    end
    push_wr(cyc + 1, 4'h9, 10'h055, 1'b1, 1'b0);
    next_cycle;
    set_req(0, 1'b0, '0, '0, 1'b0);
    repeat (2) next_cycle;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_reset got %0d pending required 0", sb.size());
    end
  endtask

  task automatic test_single;
    set_req(0, 1'b1, 4'h5, 10'h123, 1'b1);
    #1;
    checks++;
    if (hif.req_ready_o !== 2'b01) begin
      errors++;
      $display("FAIL single_req0_ready got %b required 01", hif.req_ready_o);
    end
    push_wr(cyc + 1, 4'h5, 10'h123, 1'b1, 1'b0);
    next_cycle;
    set_req(0, 1'b0, '0, '0, 1'b0);
    set_req(1, 1'b1, 4'hA, 10'h3FF, 1'b0);
    #1;
    checks++;
    if (hif.req_ready_o !== 2'b10) begin
      errors++;
      $display("FAIL single_req1_ready got %b required 10", hif.req_ready_o);
    end
    push_wr(cyc + 1, 4'hA, 10'h3FF, 1'b0, 1'b0);
    next_cycle;
    set_req(1, 1'b0, '0, '0, 1'b0);
    #1;
    checks++;
    if (hif.req_ready_o !== 2'b00) begin
      errors++;
      $display("FAIL single_idle_ready got %b required 00", hif.req_ready_o);
    end
    repeat (2) next_cycle;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_single got %0d pending required 0", sb.size());
    end
  endtask

  task automatic test_contention;
    logic [BW-1:0] a0 [3];
    logic [BW-1:0] a1 [3];
    logic [PW-1:0] p0 [3];
    logic [PW-1:0] p1 [3];
    logic          v0 [3];
    logic          v1 [3];
    int            eg [4];
    int            n0;
    int            n1;
    logic [RC-1:0] exp_rdy;
    a0 = '{4'h1, 4'h2, 4'h3};  p0 = '{10'h101, 10'h102, 10'h103}; v0 = '{1'b1, 1'b0, 1'b1};
    a1 = '{4'hE, 4'hF, 4'hD};  p1 = '{10'h201, 10'h202, 10'h203}; v1 = '{1'b1, 1'b1, 1'b0};
    eg = '{0, 1, 0, 1};
    n0 = 0;
    n1 = 0;
    set_req(0, 1'b1, a0[0], p0[0], v0[0]);
    set_req(1, 1'b1, a1[0], p1[0], v1[0]);
    for (int t = 0; t < 4; t++) begin
      #1;
      exp_rdy = (eg[t] == 0) ? 2'b01 : 2'b10;
      checks++;
      if (hif.req_ready_o !== exp_rdy) begin
        errors++;
        $display("FAIL contention_grant%0d got %b required %b", t, hif.req_ready_o, exp_rdy);
      end
      if (eg[t] == 0) begin
        push_wr(cyc + 1, a0[n0], p0[n0], v0[n0], 1'b0);
        n0++;
      end else begin
        push_wr(cyc + 1, a1[n1], p1[n1], v1[n1], 1'b0);
        n1++;
      end
      next_cycle;
      set_req(0, 1'b1, a0[n0], p0[n0], v0[n0]);
      set_req(1, 1'b1, a1[n1], p1[n1], v1[n1]);
    end
    set_req(0, 1'b0, '0, '0, 1'b0);
    set_req(1, 1'b0, '0, '0, 1'b0);
    repeat (2) next_cycle;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_contention got %0d pending required 0", sb.size());
    end
  endtask

  task automatic test_clear_in_run;
    int p;
    set_req(0, 1'b1, 4'h2, 10'h011, 1'b1);
    #1;
    checks++;
    if (hif.req_ready_o !== 2'b01) begin
      errors++;
      $display("FAIL pre_clear_ready got %b required 01", hif.req_ready_o);
    end
    push_wr(cyc + 1, 4'h2, 10'h011, 1'b1, 1'b0);
    next_cycle;
    set_req(0, 1'b0, '0, '0, 1'b0);
    set_req(1, 1'b1, 4'h3, 10'h077, 1'b1);
    clear_start = 1'b1;
    #1;
    checks++;
    if (hif.req_ready_o !== 2'b00) begin
      errors++;
      $display("FAIL clear_prio_ready got %b required 00", hif.req_ready_o);
    end
    p = cyc;
    push_sweep(p + 2);
    next_cycle;
    clear_start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      checks++;
      if (clear_busy !== 1'b1 || hif.req_ready_o !== 2'b00) begin
        errors++;
        $display("FAIL clear_run_cycle%0d got busy=%b ready=%b required busy=1 ready=00",
                 k, clear_busy, hif.req_ready_o);
      end
      next_cycle;
    end
    checks++;
    if (clear_busy !== 1'b0 || hif.req_ready_o !== 2'b10) begin
      errors++;
      $display("FAIL post_clear_grant got busy=%b ready=%b required busy=0 ready=10",
               clear_busy, hif.req_ready_o);
    end
    push_wr(cyc + 1, 4'h3, 10'h077, 1'b1, 1'b0);
    next_cycle;
    set_req(1, 1'b0, '0, '0, 1'b0);
    repeat (2) next_cycle;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_clear_in_run got %0d pending required 0", sb.size());
    end
  endtask

  task automatic test_reset_mid_sweep;
    int p;
    clear_start = 1'b1;
    p = cyc;
    for (int k = 0; k < 8; k++) push_wr(p + 2 + k, BW'(k), '0, 1'b0, 1'b0);
    next_cycle;
    clear_start = 1'b0;
    repeat (8) next_cycle;
    checks++;
    if (hif.ht_wr_addr_o !== 4'h7) begin
      errors++;
      $display("FAIL mid_sweep_addr got %h required 7", hif.ht_wr_addr_o);
    end
    rst_n = 1'b0;
    next_cycle;
    checks++;
    if (clear_busy !== 1'b1 || hif.ht_wr_en_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_sweep_reset got busy=%b en=%b required busy=1 en=0",
               clear_busy, hif.ht_wr_en_o);
    end
    rst_n = 1'b1;
    push_sweep(cyc + 1);
    repeat (16) next_cycle;
    checks++;
    if (clear_done !== 1'b1 || clear_busy !== 1'b0) begin
      errors++;
      $display("FAIL restart_done got done=%b busy=%b required done=1 busy=0",
               clear_done, clear_busy);
    end
    next_cycle;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_reset_mid got %0d pending required 0", sb.size());
    end
  endtask

  task automatic test_clear_during_clear;
    int p;
    clear_start = 1'b1;
    p = cyc;
    push_sweep(p + 2);
    next_cycle;
    clear_start = 1'b0;
    repeat (4) next_cycle;
    checks++;
    if (hif.ht_wr_addr_o !== 4'h3) begin
      errors++;
      $display("FAIL clear_at3_addr got %h required 3", hif.ht_wr_addr_o);
    end
    clear_start = 1'b1;
    next_cycle;
    clear_start = 1'b0;
    repeat (11) next_cycle;
    checks++;
    if (cyc != p + 17 || clear_done !== 1'b1 || clear_busy !== 1'b0) begin
      errors++;
      $display("FAIL no_restart_done got done=%b busy=%b at cyc %0d required done=1 busy=0 at cyc %0d",
               clear_done, clear_busy, cyc, p + 17);
    end
    next_cycle;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_clear_clear got %0d pending required 0", sb.size());
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_contention;
    test_clear_in_run;
    test_reset_mid_sweep;
    test_clear_during_clear;
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/head_table_wr_arb.md
Name: head_table_wr_arb

Overview:
Write-side controller for the hash-table head table (bucket -> head pointer RAM).
- Shares the single head-table write port between REQ_CNT requesters (insert engine, delete engine, ...) using round-robin arbitration.
- Owns the table-clear sequencer, which sweeps every bucket and writes ptr_val=0 after reset or on command.
- Drives the head-table write-port signals: wr_addr, wr_data_ptr, wr_data_ptr_val, wr_en.

Parameters:
BUCKET_WIDTH, 8, bucket address width; the table has 2**BUCKET_WIDTH entries.
HEAD_PTR_WIDTH, 10, head pointer width.
REQ_CNT, 2, number of write requesters (>=1).

Ports:
clk_i  input  1  clock
rst_n_i  input  1  synchronous reset, active-low
clear_start_i  input  1  pulse: start a full-table clear
clear_busy_o  output  1  clear sweep in progress (state == CLEAR)
clear_done_o  output  1  1-cycle pulse: last clear write presented
req_val_i  input  REQ_CNT  per-requester write valid
req_addr_i  input  REQ_CNT*BUCKET_WIDTH  per-requester bucket; requester i uses slice [i*BUCKET_WIDTH +: BUCKET_WIDTH]
req_ptr_i  input  REQ_CNT*HEAD_PTR_WIDTH  per-requester head pointer; packed the same way
req_ptr_val_i  input  REQ_CNT  per-requester head-pointer valid flag
req_ready_o  output  REQ_CNT  per-requester grant/accept
ht_wr_addr_o  output  BUCKET_WIDTH  head-table write address
ht_wr_data_ptr_o  output  HEAD_PTR_WIDTH  head-table write pointer
ht_wr_data_ptr_val_o  output  1  head-table pointer-valid bit
ht_wr_en_o  output  1  head-table write enable

Behaviour:
States and reset:
- Two states: CLEAR and RUN.
- While rst_n_i=0: state<=CLEAR, clr_cnt<=0, rr_ptr<=0, clear_done_o<=0, and all ht_* outputs <=0.
- clear_busy_o is decoded from state, so it reads 1 during reset and after reset release.

CLEAR:
- Each cycle, register a write: addr=clr_cnt, ptr=0, ptr_val=0, wr_en=1. Then clr_cnt++.
- When clr_cnt == 2**BUCKET_WIDTH-1: next state RUN, clr_cnt<=0, and clear_done_o<=1 in the same registered cycle that the final address is presented.
- A full sweep takes exactly 2**BUCKET_WIDTH cycles, each address written once in ascending order.
- req_ready_o is all 0 in CLEAR.
- clear_start_i is ignored in CLEAR; the sweep does not restart.

RUN:
- Grant logic is combinational from req_val_i and rr_ptr. The grant goes to the first requester with val=1, searching rr_ptr, rr_ptr+1, ... modulo REQ_CNT.
- req_ready_o is one-hot on the granted requester, or zero when no requester is valid.
- ready is only ever asserted for a requester whose val=1.
- A transfer occurs when val & ready. The next cycle registers ht_wr_en_o=1 with that requester's addr/ptr/ptr_val, giving 1-cycle latency.
- After a grant to requester i: rr_ptr<=(i+1) mod REQ_CNT. With no grant, rr_ptr holds.
- With no grant: ht_wr_en_o<=0, and addr/ptr/ptr_val hold their previous values.
- Requesters must hold val and payload stable until ready.

clear_start_i in RUN:
- Takes priority: req_ready_o is all 0 that cycle and no grant is made.
- Next state is CLEAR with clr_cnt=0; the first clear write appears 2 cycles after the pulse.
- A write registered in the previous cycle still completes.

Reset mid-operation:
- Reset mid-sweep aborts the sweep; a full sweep from address 0 restarts after release.
- Reset in RUN drops any in-flight output write (wr_en<=0).

Outputs:
- All ht_* outputs and clear_done_o are registered.
- req_ready_o and clear_busy_o are combinational from registered state.

Test Plan:
Use BUCKET_WIDTH=4, REQ_CNT=2, HEAD_PTR_WIDTH=10 unless stated.
1. Reset release: hold rst_n_i=0 for 3 cycles, then release. Required: ht_wr_en_o=1 with addr 0..15 (ptr=0, val=0) on cycles 1..16 after release; clear_done_o=1 only on cycle 16; clear_busy_o=0 and req_ready_o enabled from cycle 16.
2. Single requester: req0 val=1, addr=5, ptr=0x123, ptr_val=1. Required: ready0=1 in the same cycle; next cycle ht_wr_en_o=1, addr=5, ptr=0x123, val=1; ready1=0.
3. Contention: both requesters valid for 4 consecutive cycles with rr_ptr=0. Required: grants 0,1,0,1 and outputs reflect each requester's payload 1 cycle later.
4. clear_start_i pulsed in RUN while req1 is valid. Required: ready1=0 that cycle; clear writes of addr 0..15 start 2 cycles later; req1 is granted after clear_done_o.
5. rst_n_i=0 for 1 cycle at clear address 7. Required: after release the sweep restarts at addr 0 and clear_done_o fires 16 cycles later.
6. clear_start_i pulsed during CLEAR at address 3. Required: the sweep is not restarted and clear_done_o occurs at the original timing.
